// File: rtl/data_cache_if.sv
// Memory-side bus of the data cache.
// The cache is the master: it requests a whole-block fill (readM) or a
// single-word write (writeM). Memory answers each request with a one-cycle
// memReady pulse.
//   readM      cache -> mem  block-fill request
//   writeM     cache -> mem  word-write request
//   addressM   cache -> mem  word address (block aligned for fills)
//   dataM_out  cache -> mem  store word
//   dataM_in   mem -> cache  fill block, word 0 in the low bits
//   memReady   mem -> cache  fill data valid / write accepted
interface data_cache_if #(
    parameter int WORD_SIZE = 16
);
    logic                   readM;
    logic                   writeM;
    logic [WORD_SIZE-1:0]   addressM;
    logic [WORD_SIZE-1:0]   dataM_out;
    logic [4*WORD_SIZE-1:0] dataM_in;
    logic                   memReady;

    modport master (
        output readM, writeM, addressM, dataM_out,
        input  dataM_in, memReady
    );

    modport slave (
        input  readM, writeM, addressM, dataM_out,
        output dataM_in, memReady
    );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache between the
// CPU MEM stage and data memory. Lines hold 4 words.
// Ports:
//   Clk, Reset_N            clock (rising edge), async active-low reset
//   readC, writeC           CPU load/store requests, held until served
//   address, writeCacheData CPU word address and store data
//   cacheData               load data (0 unless a load hits this cycle)
//   cacheHit                1 = request served this cycle or none pending
//   writeToData             1 while a store is being written to memory
//   mem                     memory bus (data_cache_if.master)
// Optional build macro DCACHE_STATS_EN adds hitCount/missCount outputs.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | lookup; serve load hits in the same cycle, dispatch misses
// S_FILL  | fetch the whole block for a load miss
// S_WRITE | write-through of a store to memory
// S_WDONE | one-cycle store retire (cacheHit=1, writeToData=0)
module data_cache #(
    parameter int WORD_SIZE  = 16,
    parameter int INDEX_BITS = 2
) (
    input  logic                 Clk,
    input  logic                 Reset_N,
    input  logic                 readC,
    input  logic                 writeC,
    input  logic [WORD_SIZE-1:0] address,
    input  logic [WORD_SIZE-1:0] writeCacheData,
    output logic [WORD_SIZE-1:0] cacheData,
    output logic                 cacheHit,
    output logic                 writeToData,
`ifdef DCACHE_STATS_EN
    output logic [15:0]          hitCount,
    output logic [15:0]          missCount,
`endif
    data_cache_if.master         mem
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = WORD_SIZE - INDEX_BITS - 2;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_WDONE} state_t;

    state_t                  state;
    logic [LINES-1:0]        valid_q;
    logic [TAG_BITS-1:0]     tag_q  [LINES];
    logic [WORD_SIZE-1:0]    data_q [LINES][4];

    logic [1:0]              offset;
    logic [INDEX_BITS-1:0]   index;
    logic [TAG_BITS-1:0]     tag;
    logic                    hit;

    assign offset = address[1:0];
    assign index  = address[INDEX_BITS+1:2];
    assign tag    = address[WORD_SIZE-1:INDEX_BITS+2];
    assign hit    = valid_q[index] && (tag_q[index] == tag);

    // Only the valid bits need reset; tags and data are qualified by them.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state   <= S_IDLE;
            valid_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (writeC)
                        state <= S_WRITE;
                    else if (readC && !hit)
                        state <= S_FILL;
                end
                S_FILL: begin
                    if (mem.memReady) begin
                        valid_q[index] <= 1'b1;
                        state          <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    if (mem.memReady)
                        state <= S_WDONE;
                end
                S_WDONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // A store hit updates the line in the dispatch cycle so the line stays
    // coherent with the word being written through; store misses never allocate.
    always_ff @(posedge Clk) begin
        if (state == S_FILL && mem.memReady) begin
            tag_q[index] <= tag;
            for (int w = 0; w < 4; w++)
                data_q[index][w] <= mem.dataM_in[w*WORD_SIZE +: WORD_SIZE];
        end else if (state == S_IDLE && writeC && hit) begin
            data_q[index][offset] <= writeCacheData;
        end
    end

    always_comb begin
        cacheData     = '0;
        cacheHit      = 1'b0;
        writeToData   = 1'b0;
        mem.readM     = 1'b0;
        mem.writeM    = 1'b0;
        mem.addressM  = '0;
        mem.dataM_out = '0;
        case (state)
            S_IDLE: begin
                if (writeC) begin
                    cacheHit = 1'b0;
                end else if (readC) begin
                    cacheHit = hit;
                    if (hit)
                        cacheData = data_q[index][offset];
                end else begin
                    cacheHit = 1'b1;
                end
            end
            S_FILL: begin
                mem.readM    = 1'b1;
                mem.addressM = {address[WORD_SIZE-1:2], 2'b00};
            end
            S_WRITE: begin
                mem.writeM    = 1'b1;
                mem.addressM  = address;
                mem.dataM_out = writeCacheData;
                writeToData   = 1'b1;
            end
            S_WDONE: cacheHit = 1'b1;
            default: cacheHit = 1'b0;
        endcase
    end

`ifdef DCACHE_STATS_EN
    // The first IDLE cycle after a fill is the retire of the miss itself,
    // so it must not also count as a hit.
    logic after_fill_q;

    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            hitCount     <= '0;
            missCount    <= '0;
            after_fill_q <= 1'b0;
        end else begin
            after_fill_q <= (state == S_FILL) && mem.memReady;
            if (state == S_IDLE && readC && !writeC) begin
                if (!hit)
                    missCount <= missCount + 16'd1;
                else if (!after_fill_q)
                    hitCount <= hitCount + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;

    logic        Clk = 1'b0;
    logic        Reset_N = 1'b1;
    logic        readC = 1'b0;
    logic        writeC = 1'b0;
    logic [15:0] address = '0;
    logic [15:0] writeCacheData = '0;
    logic [15:0] cacheData;
    logic        cacheHit;
    logic        writeToData;
`ifdef DCACHE_STATS_EN
    logic [15:0] hitCount;
    logic [15:0] missCount;
`endif

    data_cache_if bus ();

    data_cache dut (
        .Clk            (Clk),
        .Reset_N        (Reset_N),
        .readC          (readC),
        .writeC         (writeC),
        .address        (address),
        .writeCacheData (writeCacheData),
        .cacheData      (cacheData),
        .cacheHit       (cacheHit),
        .writeToData    (writeToData),
`ifdef DCACHE_STATS_EN
        .hitCount       (hitCount),
        .missCount      (missCount),
`endif
        .mem            (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit          is_wr;
        logic [15:0] addr;
        logic [15:0] data;
        int          stall;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b1;
    int          mem_lat = 4;
    logic [15:0] cur_addr = '0;
    logic [15:0] cur_data = '0;

    // Reference: word-addressed memory image plus a tag directory.
    logic [15:0] phys_mem [0:1023];
    logic [15:0] ref_mem  [0:1023];
    bit          ref_valid [4];
    int          ref_tag   [4];
    int          exp_hits = 0;
    int          exp_misses = 0;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: pulses memReady mem_lat cycles after a request appears.
    initial begin
        bus.memReady = 1'b0;
        bus.dataM_in = '0;
        forever begin
            @(negedge Clk);
            bus.memReady = 1'b0;
            if (Reset_N && (bus.readM || bus.writeM)) begin
                bit is_rd;
                bit alive;
                is_rd = bus.readM;
                alive = 1'b1;
                if (is_rd)
                    check_eq("fill_addr", {32'd0, bus.addressM}, {32'd0, cur_addr[15:2], 2'b00});
                else
                    check_eq("write_bus", {15'd0, writeToData, bus.addressM, bus.dataM_out},
                             {15'd0, 1'b1, cur_addr, cur_data});
                for (int i = 0; i < mem_lat; i++) begin
                    @(negedge Clk);
                    if (!(bus.readM || bus.writeM)) begin
                        alive = 1'b0;
                        break;
                    end
                end
                if (alive) begin
                    if (is_rd) begin
                        for (int k = 0; k < 4; k++) begin
                            logic [9:0] ma;
                            ma = {bus.addressM[9:2], 2'b00} + 10'(k);
                            bus.dataM_in[k*16 +: 16] = phys_mem[ma];
                        end
                    end else begin
                        phys_mem[bus.addressM[9:0]] = bus.dataM_out;
                    end
                    bus.memReady = 1'b1;
                end
            end
        end
    end

    // Monitor: every served request pops one expectation.
    initial begin
        int stall;
        exp_t e;
        stall = 0;
        forever begin
            @(negedge Clk);
            if (!mon_en || !Reset_N) begin
                stall = 0;
            end else if (readC || writeC) begin
                if (!cacheHit) begin
                    stall++;
                end else begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_done", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("done_kind", {63'd0, writeC}, {63'd0, e.is_wr});
                        check_eq("stall_cycles", 64'(stall), 64'(e.stall));
                        check_eq("bus_idle_at_done", {62'd0, bus.readM, bus.writeM}, 64'd0);
                        if (e.is_wr) begin
                            check_eq("store_retire", {31'd0, writeToData, cacheData, phys_mem[e.addr[9:0]]},
                                     {31'd0, 1'b0, 16'h0000, e.data});
                        end else begin
                            check_eq("load_data", {48'd0, cacheData}, {48'd0, e.data});
                        end
                    end
                    stall = 0;
                end
            end
        end
    end

    task automatic do_txn(input bit wr, input bit rd, input logic [15:0] a,
                          input logic [15:0] d, input int lat);
        exp_t e;
        int   idx;
        int   tg;
        bit   h;
        int   n;
        idx = int'(a[3:2]);
        tg  = int'(a[15:4]);
        h   = ref_valid[idx] && (ref_tag[idx] == tg);
        e.is_wr = wr;
        e.addr  = a;
        if (wr) begin
            ref_mem[a[9:0]] = d;
            e.data  = d;
            e.stall = lat + 2;
        end else begin
            e.data  = ref_mem[a[9:0]];
            e.stall = h ? 0 : lat + 2;
            if (h) begin
                exp_hits++;
            end else begin
                exp_misses++;
                ref_valid[idx] = 1'b1;
                ref_tag[idx]   = tg;
            end
        end
        exp_q.push_back(e);
        mem_lat        = lat;
        cur_addr       = a;
        cur_data       = d;
        address        = a;
        writeCacheData = d;
        writeC         = wr;
        readC          = wr ? rd : 1'b1;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!cacheHit && n < 200);
        if (!cacheHit)
            check_eq("txn_timeout", {63'd0, cacheHit}, 64'd1);
        @(posedge Clk);
        #1;
        readC  = 1'b0;
        writeC = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge Clk);
        check_eq("idle_outputs",
                 {43'd0, cacheHit, cacheData, writeToData, bus.readM, bus.writeM, bus.addressM},
                 {43'd0, 1'b1, 16'h0000, 3'b000, 16'h0000});
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            ref_valid[i] = 1'b0;
            ref_tag[i]   = 0;
        end
        exp_hits   = 0;
        exp_misses = 0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            phys_mem[i] = 16'($urandom);
            ref_mem[i]  = phys_mem[i];
        end
        phys_mem[16'h0010] = 16'hAAAA; ref_mem[16'h0010] = 16'hAAAA;
        phys_mem[16'h0011] = 16'h1234; ref_mem[16'h0011] = 16'h1234;
        phys_mem[16'h0012] = 16'h5555; ref_mem[16'h0012] = 16'h5555;
        phys_mem[16'h0013] = 16'hBEEF; ref_mem[16'h0013] = 16'hBEEF;
        clear_model();

        #2 Reset_N = 1'b0;
        #1;
        check_eq("reset_outputs",
                 {43'd0, cacheHit, cacheData, writeToData, bus.readM, bus.writeM, bus.addressM},
                 {43'd0, 1'b1, 16'h0000, 3'b000, 16'h0000});
        check_eq("reset_dataM_out", {48'd0, bus.dataM_out}, 64'd0);
`ifdef DCACHE_STATS_EN
        check_eq("reset_counters", {32'd0, hitCount, missCount}, 64'd0);
`endif
        repeat (2) @(posedge Clk);
        #1 Reset_N = 1'b1;
        idle_cycle();

        // Directed scenarios
        do_txn(0, 1, 16'h0013, 16'h0000, 4);
        do_txn(0, 1, 16'h0011, 16'h0000, 4);
        do_txn(1, 0, 16'h0011, 16'hCAFE, 3);
        do_txn(0, 1, 16'h0011, 16'h0000, 3);
        do_txn(1, 0, 16'h0040, 16'h7777, 2);
        do_txn(0, 1, 16'h0040, 16'h0000, 2);
        do_txn(0, 1, 16'h0010, 16'h0000, 1);
        do_txn(0, 1, 16'h0050, 16'h0000, 1);
        do_txn(0, 1, 16'h0010, 16'h0000, 0);
        do_txn(1, 1, 16'h0012, 16'h4321, 1);
        do_txn(0, 1, 16'h0012, 16'h0000, 1);
        idle_cycle();

        // Randomized traffic over a small address window so hits and conflicts are frequent
        for (int t = 0; t < 200; t++) begin
            int          r;
            logic [15:0] a;
            r = int'($urandom_range(0, 9));
            a = 16'(($urandom_range(0, 3) << 8) | $urandom_range(0, 15));
            if (r < 6)
                do_txn(0, 1, a, 16'h0000, int'($urandom_range(0, 4)));
            else if (r < 9)
                do_txn(1, 0, a, 16'($urandom), int'($urandom_range(0, 4)));
            else
                do_txn(1, 1, a, 16'($urandom), int'($urandom_range(0, 4)));
            if ($urandom_range(0, 3) == 0)
                idle_cycle();
        end
`ifdef DCACHE_STATS_EN
        check_eq("random_counters", {32'd0, hitCount, missCount},
                 {32'd0, 16'(exp_hits), 16'(exp_misses)});
`endif

        // Reset in the middle of a fill
        mon_en   = 1'b0;
        mem_lat  = 10;
        cur_addr = 16'h0010;
        address  = 16'h0010;
        readC    = 1'b1;
        repeat (3) @(negedge Clk);
        check_eq("fill_in_progress", {63'd0, bus.readM}, 64'd1);
        #2;
        Reset_N = 1'b0;
        readC   = 1'b0;
        #1;
        check_eq("reset_mid_fill",
                 {44'd0, cacheHit, bus.readM, bus.writeM, writeToData, cacheData},
                 {44'd0, 4'b1000, 16'h0000});
`ifdef DCACHE_STATS_EN
        check_eq("reset_mid_fill_counters", {32'd0, hitCount, missCount}, 64'd0);
`endif
        @(posedge Clk);
        #1 Reset_N = 1'b1;
        clear_model();
        mon_en = 1'b1;
        idle_cycle();
        do_txn(0, 1, 16'h0010, 16'h0000, 2);
        do_txn(0, 1, 16'h0011, 16'h0000, 2);
        do_txn(0, 1, 16'h0050, 16'h0000, 2);
        do_txn(0, 1, 16'h0010, 16'h0000, 2);
        do_txn(0, 1, 16'h0012, 16'h0000, 2);
`ifdef DCACHE_STATS_EN
        check_eq("counters_3m_2h", {32'd0, hitCount, missCount}, {32'd0, 16'd2, 16'd3});
`endif

        begin
            int n;
            n = 0;
            while (exp_q.size() != 0 && n < 20) begin
                @(negedge Clk);
                n++;
            end
            check_eq("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
